// File: rtl/rst_seq_ctrl_if.sv
// Bundle of soft-reset request, release-gap configuration and per-domain
// reset/clock-gate outputs of the reset sequencer.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned DLY_WIDTH   = 4
);
  logic                   soft_req;
  logic [1:0]             soft_dom;
  logic [DLY_WIDTH-1:0]   dly_cfg;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic [NUM_DOMAINS-1:0] clk_gate_en;
  logic                   busy;
  logic                   seq_done;
  logic                   soft_ack;

  modport master (
    output soft_req, soft_dom, dly_cfg,
    input  dom_rst_n, clk_gate_en, busy, seq_done, soft_ack
  );

  modport slave (
    input  soft_req, soft_dom, dly_cfg,
    output dom_rst_n, clk_gate_en, busy, seq_done, soft_ack
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Power-up reset sequencer: holds all domains in reset, optionally enables clocks,
// then releases domains in index order; supports per-domain soft resets once done.
// Optional feature macro: RST_SEQ_CLK_GATE_EN (clock-gate sequencing and GATE_ON state).
module rst_seq_ctrl #(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned DLY_WIDTH   = 4,
  parameter int unsigned MIN_ASSERT  = 4
) (
  input logic           CLK,
  input logic           RST,
  rst_seq_ctrl_if.slave bus
);
  localparam int unsigned HOLD_W = $clog2(MIN_ASSERT + 1);
  localparam int unsigned GAP_W  = DLY_WIDTH + 1;
  localparam int unsigned IDX_W  = 2;

`ifdef RST_SEQ_CLK_GATE_EN
  localparam logic [NUM_DOMAINS-1:0] GATE_RST = '0;
`else
  localparam logic [NUM_DOMAINS-1:0] GATE_RST = '1;
`endif

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
`ifdef RST_SEQ_CLK_GATE_EN
    ST_GATE_ON = 3'd1,
`endif
    ST_RELEASE = 3'd2,
    ST_DONE    = 3'd3,
    ST_SOFT    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
  logic [NUM_DOMAINS-1:0] clk_gate_en_q, clk_gate_en_d;
  logic                   busy_q, busy_d;
  logic                   seq_done_q, seq_done_d;
  logic                   soft_ack_q, soft_ack_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [1:0]             soft_dom_q, soft_dom_d;
  logic                   armed_q, armed_d;

  logic [GAP_W-1:0]       gap_load;
  logic                   hold_last;
  logic                   dom_legal;

  // One-hot mask selecting a domain by index
  function automatic logic [NUM_DOMAINS-1:0] dom_mask(input logic [IDX_W-1:0] idx);
    logic [NUM_DOMAINS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
      m[i] = (IDX_W'(i) == idx);
    end
    return m;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_ASSERT;
      dom_rst_n_q   <= '0;
      clk_gate_en_q <= GATE_RST;
      busy_q        <= 1'b1;
      seq_done_q    <= 1'b0;
      soft_ack_q    <= 1'b0;
      hold_q        <= '0;
      gap_q         <= '0;
      idx_q         <= '0;
      soft_dom_q    <= '0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dom_rst_n_q   <= dom_rst_n_d;
      clk_gate_en_q <= clk_gate_en_d;
      busy_q        <= busy_d;
      seq_done_q    <= seq_done_d;
      soft_ack_q    <= soft_ack_d;
      hold_q        <= hold_d;
      gap_q         <= gap_d;
      idx_q         <= idx_d;
      soft_dom_q    <= soft_dom_d;
      armed_q       <= armed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    dom_rst_n_d   = dom_rst_n_q;
    clk_gate_en_d = clk_gate_en_q;
    busy_d        = busy_q;
    seq_done_d    = seq_done_q;
    soft_ack_d    = 1'b0;
    hold_d        = hold_q;
    gap_d         = gap_q;
    idx_d         = idx_q;
    soft_dom_d    = soft_dom_q;
    // A low sample of soft_req re-arms acceptance of the next request
    armed_d       = armed_q | ~bus.soft_req;
    gap_load      = GAP_W'(bus.dly_cfg) + GAP_W'(1);
    hold_last     = (hold_q == HOLD_W'(MIN_ASSERT - 1));
    dom_legal     = (32'(bus.soft_dom) < NUM_DOMAINS);

    case (state_q)
      ST_ASSERT: begin
        dom_rst_n_d = '0;
        busy_d      = 1'b1;
        seq_done_d  = 1'b0;
        if (hold_last) begin
          hold_d = '0;
`ifdef RST_SEQ_CLK_GATE_EN
          state_d       = ST_GATE_ON;
          clk_gate_en_d = '1;
`else
          state_d     = ST_RELEASE;
          dom_rst_n_d = dom_mask(IDX_W'(0));
          idx_d       = IDX_W'(1);
          gap_d       = gap_load;
`endif
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

`ifdef RST_SEQ_CLK_GATE_EN
      // Two cycles of running clock with reset held so synchronizers flush
      ST_GATE_ON: begin
        if (hold_q == HOLD_W'(1)) begin
          hold_d      = '0;
          state_d     = ST_RELEASE;
          dom_rst_n_d = dom_mask(IDX_W'(0));
          idx_d       = IDX_W'(1);
          gap_d       = gap_load;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
`endif

      ST_RELEASE: begin
        if (gap_q == GAP_W'(1)) begin
          dom_rst_n_d = dom_rst_n_q | dom_mask(idx_q);
          if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            seq_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            gap_d = gap_load;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      ST_DONE: begin
        if (bus.soft_req && armed_q && dom_legal) begin
          state_d     = ST_SOFT;
          soft_dom_d  = bus.soft_dom;
          dom_rst_n_d = dom_rst_n_q & ~dom_mask(bus.soft_dom);
          busy_d      = 1'b1;
          armed_d     = 1'b0;
          hold_d      = '0;
        end
      end

      ST_SOFT: begin
        if (hold_last) begin
          state_d     = ST_DONE;
          dom_rst_n_d = dom_rst_n_q | dom_mask(soft_dom_q);
          soft_ack_d  = 1'b1;
          busy_d      = 1'b0;
          armed_d     = 1'b0;
          hold_d      = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = ST_ASSERT;
    endcase
  end

  assign bus.dom_rst_n   = dom_rst_n_q;
  assign bus.clk_gate_en = clk_gate_en_q;
  assign bus.busy        = busy_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.soft_ack    = soft_ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: the driver queues the expected outputs for each
// edge, a monitor pops and compares them just after that edge.
module tb_rst_seq_ctrl;
  localparam int ND = 3;
  localparam int DW = 4;
  localparam int MA = 4;
`ifdef RST_SEQ_CLK_GATE_EN
  localparam int             GATE_CYC = 2;
  localparam logic [ND-1:0]  GATE_RST = '0;
`else
  localparam int             GATE_CYC = 0;
  localparam logic [ND-1:0]  GATE_RST = '1;
`endif
  localparam int R0 = MA + GATE_CYC;

  typedef struct {
    logic [ND-1:0] rst_n;
    logic [ND-1:0] gate;
    logic          busy;
    logic          done;
    logic          ack;
    string         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sbq[$];
  exp_t me;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_DOMAINS(ND), .DLY_WIDTH(DW)) bus ();

  rst_seq_ctrl #(.NUM_DOMAINS(ND), .DLY_WIDTH(DW), .MIN_ASSERT(MA)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Monitor: compare queued expectation against outputs just after each edge
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      n_tests++;
      if ({bus.dom_rst_n, bus.clk_gate_en, bus.busy, bus.seq_done, bus.soft_ack} !==
          {me.rst_n, me.gate, me.busy, me.done, me.ack}) begin
        n_fail++;
        $display("FAIL %s: got rst_n=%b gate=%b busy=%b done=%b ack=%b, want rst_n=%b gate=%b busy=%b done=%b ack=%b",
                 me.tag, bus.dom_rst_n, bus.clk_gate_en, bus.busy, bus.seq_done, bus.soft_ack,
                 me.rst_n, me.gate, me.busy, me.done, me.ack);
      end
    end
  end

  task automatic expect_edge(input logic [ND-1:0] r, input logic [ND-1:0] g,
                             input logic b, input logic d, input logic a, input string tag);
    exp_t e;
    e.rst_n = r; e.gate = g; e.busy = b; e.done = d; e.ack = a; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset then power-up; dly_cfg is d1 before edge chg and d2 from it on,
  // soft_req is high for edges req_lo..req_hi, stop_at>0 ends early.
  task automatic powerup(input int rst_cyc, input logic [DW-1:0] d1, input int chg,
                         input logic [DW-1:0] d2, input int req_lo, input int req_hi,
                         input int stop_at, input string tag);
    int            rel[ND];
    logic [DW-1:0] dv;
    logic [ND-1:0] r, g;
    rel[0] = R0;
    for (int i = 1; i < ND; i++) begin
      dv     = (rel[i-1] >= chg) ? d2 : d1;
      rel[i] = rel[i-1] + int'(dv) + 1;
    end
    rst = 1'b1;
    for (int k = 0; k < rst_cyc; k++)
      expect_edge('0, GATE_RST, 1'b1, 1'b0, 1'b0, $sformatf("%s_rst%0d", tag, k));
    rst = 1'b0;
    for (int n = 1; n <= rel[ND-1] + 2; n++) begin
      bus.dly_cfg  = (n >= chg) ? d2 : d1;
      bus.soft_req = (n >= req_lo) && (n <= req_hi);
      for (int i = 0; i < ND; i++) r[i] = (n >= rel[i]);
`ifdef RST_SEQ_CLK_GATE_EN
      g = (n >= MA) ? '1 : '0;
`else
      g = '1;
`endif
      expect_edge(r, g, n < rel[ND-1], n >= rel[ND-1], 1'b0, $sformatf("%s@%0d", tag, n));
      if (n == stop_at) return;
    end
  endtask

  // Soft reset of one domain from DONE, then request held high, then dropped
  task automatic soft_reset(input logic [1:0] dom, input string tag);
    logic [ND-1:0] r;
    for (int i = 0; i < ND; i++) r[i] = (i != int'(dom));
    bus.soft_req = 1'b1;
    bus.soft_dom = dom;
    if (int'(dom) < ND) begin
      for (int k = 0; k < MA; k++)
        expect_edge(r, '1, 1'b1, 1'b1, 1'b0, $sformatf("%s_hold%0d", tag, k));
      expect_edge('1, '1, 1'b0, 1'b1, 1'b1, {tag, "_ack"});
      for (int k = 0; k < 3; k++)
        expect_edge('1, '1, 1'b0, 1'b1, 1'b0, $sformatf("%s_held%0d", tag, k));
    end else begin
      for (int k = 0; k < 6; k++)
        expect_edge('1, '1, 1'b0, 1'b1, 1'b0, $sformatf("%s_ign%0d", tag, k));
    end
    bus.soft_req = 1'b0;
    expect_edge('1, '1, 1'b0, 1'b1, 1'b0, {tag, "_idle"});
  endtask

  initial begin
    bus.soft_req = 1'b0;
    bus.soft_dom = 2'd0;
    bus.dly_cfg  = '0;
    powerup(2, DW'(3), 1000, DW'(3), 0, 0, 0, "pu_d3");
    soft_reset(2'd1, "soft1");
    soft_reset(2'd3, "soft_bad");
    soft_reset(2'd0, "soft0");
    soft_reset(2'd2, "soft2");
    powerup(1, DW'(0), 1000, DW'(0), 0, 0, 0, "pu_d0");
    powerup(1, DW'(3), 1000, DW'(3), R0 + 1, R0 + 7, 0, "pu_early_req");
    powerup(1, DW'(3), 1000, DW'(3), 0, 0, 8, "pu_abort");
    powerup(1, DW'(3), 1000, DW'(3), 0, 0, 0, "pu_replay");
    powerup(1, DW'(3), R0 + 1, DW'(0), 0, 0, 0, "pu_chg");
    powerup(1, DW'(15), 1000, DW'(15), 0, 0, 0, "pu_max");
    // Reset arriving in the middle of a soft reset
    bus.soft_req = 1'b1;
    bus.soft_dom = 2'd2;
    expect_edge(3'b011, '1, 1'b1, 1'b1, 1'b0, "mid_soft0");
    expect_edge(3'b011, '1, 1'b1, 1'b1, 1'b0, "mid_soft1");
    powerup(1, DW'(1), 1000, DW'(1), 0, 0, 0, "pu_after_soft");
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOMAINS, default 3, number of controlled reset/clock domains (2..4).
REQ-002 Parameter DLY_WIDTH, default 4, width of the release-gap configuration.
REQ-003 Parameter MIN_ASSERT, default 4, minimum cycles a domain reset is held asserted (>=2).
REQ-004 CLK  in  1  single block clock, rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 soft_req  in  1  level request for a soft reset of one domain, held until soft_ack.
REQ-007 soft_dom  in  2  index of the domain to soft-reset; valid only with soft_req.
REQ-008 dly_cfg  in  DLY_WIDTH  gap between successive domain releases, in cycles minus one.
REQ-009 dom_rst_n  out  NUM_DOMAINS  per-domain active-low reset, one bit per domain.
REQ-010 clk_gate_en  out  NUM_DOMAINS  per-domain clock-gate enable, active-high.
REQ-011 busy  out  1  high while the power-up sequence or a soft reset is in progress.
REQ-012 seq_done  out  1  high once all domains are released; stays high until RST.
REQ-013 soft_ack  out  1  one-cycle pulse marking soft-reset completion.

Function
REQ-014 All outputs are registered; "after edge N" means visible after the Nth rising edge with RST sampled low.
REQ-015 FSM states: ASSERT, GATE_ON, RELEASE, DONE, SOFT.
REQ-016 ASSERT: all dom_rst_n=0 and clk_gate_en=0; held MIN_ASSERT cycles; moves to GATE_ON after edge MIN_ASSERT.
REQ-017 GATE_ON: clk_gate_en set to all ones with resets still asserted; held 2 cycles so downstream reset synchronizers clear; then moves to RELEASE.
REQ-018 RELEASE: releases domains in index order 0,1,...,NUM_DOMAINS-1, one per step; dom_rst_n[0] rises on entry.
REQ-019 RELEASE: the gap between successive releases is dly_cfg+1 cycles; dly_cfg is sampled when each gap begins, and later changes do not affect a running gap.
REQ-020 On the last release, the FSM goes to DONE, seq_done=1 and busy=0 on the same edge.
REQ-021 busy=1 in ASSERT, GATE_ON, RELEASE and SOFT.
REQ-022 soft_req is sampled only in DONE; requests made in any other state are ignored and not queued.
REQ-023 A new request is accepted only after soft_req has been seen low for at least one cycle since the last soft_ack.
REQ-024 Accepted request with soft_dom < NUM_DOMAINS: enter SOFT and drive dom_rst_n[soft_dom]=0 for MIN_ASSERT cycles.
REQ-025 At the end of SOFT: release dom_rst_n[soft_dom], pulse soft_ack for 1 cycle and return to DONE; soft_dom is latched at acceptance.
REQ-026 During SOFT, other domains' resets and all clk_gate_en are unchanged, and seq_done stays 1.
REQ-027 Request with soft_dom >= NUM_DOMAINS: ignored, no ack, state stays DONE.
REQ-028 Counters never wrap: the gap counter uses DLY_WIDTH+1 bits; dly_cfg=0 gives a 1-cycle gap; the maximum value gives 2^DLY_WIDTH cycles.

Reset
REQ-029 RST high at any edge, in any state including mid-RELEASE or mid-SOFT, forces the following on the next edge: ASSERT state, dom_rst_n=0, clk_gate_en=0, busy=1, seq_done=0, soft_ack=0, counters=0, request-armed flag cleared.
REQ-030 When RST is released, the sequence restarts from the beginning of ASSERT.

Configuration
REQ-031 Macro RST_SEQ_CLK_GATE_EN defined: clk_gate_en is sequenced per REQ-016/017 and the GATE_ON state exists.
REQ-032 Macro RST_SEQ_CLK_GATE_EN undefined: clk_gate_en is tied to all ones (including during RST), GATE_ON is removed, and ASSERT goes directly to RELEASE; all other timing is unchanged.

Verification
REQ-033 Power-up, macro defined, dly_cfg=3: clk_gate_en=3'b111 after edge 4; dom_rst_n bit0 after edge 6, bit1 after edge 10, bit2 after edge 14; seq_done=1 and busy=0 after edge 14.
REQ-034 Power-up, macro undefined, dly_cfg=0: dom_rst_n bit0 after edge 4, bit1 after edge 5, bit2 after edge 6; clk_gate_en=3'b111 throughout.
REQ-035 Soft reset: in DONE, soft_req=1 and soft_dom=1 sampled at edge e -> dom_rst_n=3'b101 from edge e to e+3, 3'b111 after edge e+4, soft_ack high only after edge e+4; soft_req held high afterwards causes no second reset.
REQ-036 Illegal or early request: soft_dom=3 in DONE -> no change and no ack; soft_req=1 during RELEASE -> ignored, and the release timing is identical to REQ-033.
REQ-037 Mid-sequence reset: RST pulsed for 1 cycle after edge 8 of REQ-033 -> all outputs return to reset values on the next edge, and the full sequence replays with the same relative timing.
REQ-038 dly_cfg changed from 3 to 0 mid-gap -> the current gap stays 4 cycles and the next gap is 1 cycle.
